uart_rx_os16: RTL and testbench

//   Serial receive stage. Samples the RS-232 line with 16x oversampling off the shared baud tick.

---
 rtl/uart_rx_os16.sv | 146 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling. The line is sampled at the middle of each bit.
// It also reports framing errors and line breaks for the status register.
module uart_rx_os16 #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            b_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [3:0]      s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic [DBIT-1:0] dout_next;
  logic            done_next, ferr_next, brk_next;

  // The synchronizer resets to the idle level so that leaving reset
  // cannot be mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_next;
      s         <= s_next;
      n         <= n_next;
      shreg     <= shreg_next;
      dout      <= dout_next;
      rx_done   <= done_next;
      frame_err <= ferr_next;
      break_det <= brk_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shreg_next = shreg;
    dout_next  = dout;
    done_next  = 1'b0;
    ferr_next  = 1'b0;
    brk_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end

      START: begin
        if (b_tick) begin
          if (s == 4'd7) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end

      DATA: begin
        if (b_tick) begin
          if (s == 4'd15) begin
            shreg_next = {rx_s, shreg[DBIT-1:1]};
            s_next     = '0;
            if (n == NW'(DBIT - 1)) begin
              state_next = STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end

      // The FSM closes the frame at mid stop bit. This lets a start edge that
      // immediately follows the stop bit be caught.
      STOP: begin
        if (b_tick) begin
          if (s == 4'(SB_TICK - 1)) begin
            dout_next = shreg;
            if (rx_s) begin
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next  = 1'b1;
              brk_next   = (shreg == '0);
              state_next = WAIT_HI;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end

      WAIT_HI: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Randomized scoreboard bench for uart_rx_os16. The bench queues the expected result for every
// serial frame it drives. A monitor compares that result against each pulse the DUT issues.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done, frame_err, break_det, busy;

  int vectors_applied = 0;
  int miscompares = 0;
  int tick_cnt = 0;

  typedef struct {
    logic       done;
    logic       ferr;
    logic       brk;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_os16 #(.DBIT(8), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_tick    (b_tick),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .break_det (break_det),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // b_tick fires once every 10 clocks. It changes on the falling edge.
  always @(negedge clk) begin
    if (tick_cnt == 9) tick_cnt = 0;
    else tick_cnt = tick_cnt + 1;
    b_tick = (tick_cnt == 9);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sendLevel(input logic v, input int ticks);
    rx = v;
    for (int i = 0; i < ticks; i++) begin
      @(posedge clk);
      while (!b_tick) @(posedge clk);
    end
    #1;
  endtask

  // Reference model: a good stop bit delivers the byte. A low stop bit is a framing error.
  // It is also a break when the byte is all zeros.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_ok);
    exp_t e;
    e.done = stop_ok;
    e.ferr = !stop_ok;
    e.brk  = !stop_ok && (d == 8'h00);
    e.data = d;
    exp_q.push_back(e);
    sendLevel(1'b0, 16);
    checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) sendLevel(d[i], 16);
    sendLevel(stop_ok, 16);
  endtask

  always @(negedge clk) begin
    if (rx_done || frame_err || break_det) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, rx_done, frame_err, break_det}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rx_done", {31'd0, rx_done}, {31'd0, e.done});
        checkOutput("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
        checkOutput("break_det", {31'd0, break_det}, {31'd0, e.brk});
        checkOutput("dout", {24'd0, dout}, {24'd0, e.data});
      end
    end
  end

  task automatic waitDrain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("pending_expected", exp_q.size(), 32'd0);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       ok;
    logic [7:0] v55;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_dout", {24'd0, dout}, 32'd0);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_break_det", {31'd0, break_det}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] T2 start-bit glitch");
    sendLevel(1'b1, 4);
    sendLevel(1'b0, 4);
    checkOutput("glitch_busy_low_phase", {31'd0, busy}, 32'd1);
    sendLevel(1'b1, 32);
    checkOutput("glitch_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("glitch_dout", {24'd0, dout}, 32'd0);

    $display("[TB] T1 frame 0xA5");
    applyStimulus(8'hA5, 1'b1);
    sendLevel(1'b1, 16);
    waitDrain();
    checkOutput("a5_busy_after", {31'd0, busy}, 32'd0);

    $display("[TB] T3 framing error 0x3C");
    applyStimulus(8'h3C, 1'b0);
    sendLevel(1'b0, 32);
    checkOutput("ferr_busy_held", {31'd0, busy}, 32'd1);
    sendLevel(1'b1, 16);
    checkOutput("ferr_busy_after", {31'd0, busy}, 32'd0);
    waitDrain();

    $display("[TB] T4 line break");
    exp_q.push_back('{done: 1'b0, ferr: 1'b1, brk: 1'b1, data: 8'h00});
    sendLevel(1'b0, 200);
    checkOutput("break_busy_held", {31'd0, busy}, 32'd1);
    sendLevel(1'b1, 32);
    checkOutput("break_busy_after", {31'd0, busy}, 32'd0);
    applyStimulus(8'h6E, 1'b1);
    sendLevel(1'b1, 16);
    waitDrain();

    $display("[TB] T5 back-to-back 0x00, 0xFF");
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    sendLevel(1'b1, 16);
    waitDrain();

    $display("[TB] T6 reset mid-frame");
    v55 = 8'h55;
    sendLevel(1'b0, 16);
    for (int i = 0; i < 3; i++) sendLevel(v55[i], 16);
    sendLevel(v55[3], 8);
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    sendLevel(1'b1, 32);
    checkOutput("midreset_busy_idle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h81, 1'b1);
    sendLevel(1'b1, 16);
    waitDrain();

    $display("[TB] random frames");
    for (int k = 0; k < 10; k++) begin
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (k == 3) d = 8'h00;
      applyStimulus(d, ok);
      if (!ok) begin
        sendLevel(1'b0, $urandom_range(0, 20));
        sendLevel(1'b1, $urandom_range(2, 20));
      end else begin
        sendLevel(1'b1, $urandom_range(0, 10));
      end
    end
    sendLevel(1'b1, 16);
    waitDrain();
    checkOutput("final_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
